varray_multi: RTL and testbench
===============================

Name: varray_multi

Overview:
- Parametrised successor to the single-configuration virtual array. It presents a 2^ADDR_BITS-element sparse, zero-filled virtual array to the instruction queue.
- Internally it is a DEPTH-entry run queue. Each entry holds {start, len, data}, and the data value covers virtual addresses [start, start+len).
- New compared with the earlier block:
  - generic widths and depth
  - full/empty/occupancy flags, with write backpressure
  - explicit read hit flag
  - synchronous flush
  - sticky protocol-error flag

Parameters:
- ELEMENT_WIDTH, 18, bits of data per virtual element
- ADDR_BITS, 16, virtual address width; the array holds 2^ADDR_BITS elements
- LOG_DEPTH, 6, log2 of the queue entry count; DEPTH = 2^LOG_DEPTH
- LEN_BITS, 5, width of the run length; legal run length is 1..2^LEN_BITS-1

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear; same effect as reset
- we  in  1  write request
- write_addr  in  ADDR_BITS  start address of the run being written
- write_len  in  LEN_BITS  run length
- dat_w  in  ELEMENT_WIDTH  value for every element in the run
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- occupancy  out  LOG_DEPTH+1  number of valid entries
- re  in  1  read request (advances retirement)
- read_addr  in  ADDR_BITS  virtual read address
- dat_r  out  ELEMENT_WIDTH  combinational read data
- read_hit  out  1  combinational; read_addr falls inside the tail run
- varray_len  out  ADDR_BITS+1  one past the highest written address
- is_new_group  out  1  registered superscalar-group boundary flag
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset_n low, asynchronous) or flush (synchronous, dominates we/re) sets:
  - head = tail = 0
  - varray_len = 0, err = 0, is_new_group = 1
  - hence empty = 1, full = 0, occupancy = 0
- Entry memory is not cleared. All read logic is gated by empty, so stale contents are never visible.
- Pointers are LOG_DEPTH+1 bits wide.
  - occupancy = head - tail
  - full = (occupancy == DEPTH)
  - empty = (occupancy == 0)
  - Wrap-around is handled by the extra pointer bit; all DEPTH entries are usable.
- All end/length arithmetic is ADDR_BITS+1 bits wide: end = start + len, zero-extended. No truncation is allowed.
- A write is accepted when we=1 and all of the following hold:
  - !full
  - write_len != 0
  - write_addr >= varray_len
  - write_addr + write_len <= 2^ADDR_BITS
- On an accepted write:
  - the entry at head[LOG_DEPTH-1:0] is loaded
  - head increments
  - varray_len <= write_addr + write_len (visible the next cycle)
- If we=1 and any acceptance condition fails: no state change except err <= 1. A write while full is rejected even if a retire happens in the same cycle.
- Read path (combinational, from registered state only):
  - read_hit = !empty && read_addr >= start[tail] && read_addr < end[tail]
  - dat_r = read_hit ? data[tail] : 0
  - A gap between runs reads as 0 with read_hit = 0.
- Retire: on re=1, when !empty and read_addr + 1 >= end[tail], tail increments. At most one entry retires per cycle.
- Error on read: re=1 with read_addr >= varray_len sets err <= 1 and causes no retire.
- is_new_group update, on re=1 (outside flush):
  - is_new_group <= (!read_hit || read_addr + 1 == end[tail])
  - It holds its value when re=0.
- Simultaneous we and re: both take effect.
  - A run written this cycle is not readable until the next cycle.
  - When the queue is empty, read_hit = 0 and dat_r = 0.
- Read addresses must be non-decreasing. Out-of-order reads are not detected beyond the varray_len check.
- Latency:
  - write to readable: 1 cycle
  - retire to next entry visible: 1 cycle
  - read data: 0 cycles
- err is cleared only by reset or flush.

Test Plan:
- Basic run: reset, then write (addr 0, len 3, data 5), then re at addresses 0, 1, 2.
  - dat_r = 5 and read_hit = 1 on each read.
  - is_new_group sequence after the reads: 0, 0, 1.
  - empty = 1 after addr 2; varray_len = 3.
- Gap: write (0, 2, A) then (5, 1, B); read addresses 0..5.
  - Data sequence A, A, 0, 0, 0, B.
  - read_hit = 0 at addresses 2..4; is_new_group = 1 after each gap read.
- Full and backpressure (DEPTH=64): write 64 runs of length 1.
  - full = 1, occupancy = 64.
  - A 65th write is dropped and err = 1.
  - One retire gives full = 0; the next write is accepted; the tail pointer wraps correctly.
- Illegal writes each set err and leave varray_len unchanged:
  - write_len = 0
  - write_addr < varray_len
  - write (65530, 10)
  - Write (65520, 16) is accepted and gives varray_len = 65536.
- Simultaneous operation: same-cycle we on the empty queue with re at addr 0.
  - read_hit = 0 that cycle; the entry is readable on the next cycle.
  - A same-cycle write while another entry retires is accepted.
- Reset and flush mid-stream:
  - Assert flush with 3 entries queued: next cycle empty = 1, varray_len = 0, err = 0, is_new_group = 1.
  - Pulse reset_n low between clock edges: outputs clear immediately, without waiting for a clock.

Source files
------------

// File: rtl/varray_multi.sv
`default_nettype none
// ============================================================================
//  Module   : varray_multi
//  Purpose  : Sparse, zero-filled virtual array of 2^ADDR_BITS elements built
//             from a DEPTH-entry run queue. Each queue entry describes one run
//             {start, end, data}; every virtual address in [start, end) reads
//             back as data, and every other address reads back as zero.
//             Runs are appended at the head and retired from the tail as the
//             reader walks past them with non-decreasing addresses.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    reset_n      in   asynchronous active-low reset
//    flush        in   synchronous clear, same effect as reset
//    we           in   write request
//    write_addr   in   [ADDR_BITS]      start address of the run
//    write_len    in   [LEN_BITS]       run length (1..2^LEN_BITS-1)
//    dat_w        in   [ELEMENT_WIDTH]  value of every element in the run
//    full         out  queue holds DEPTH entries
//    empty        out  queue holds no entries
//    occupancy    out  [LOG_DEPTH+1]    number of valid entries
//    re           in   read request, advances retirement
//    read_addr    in   [ADDR_BITS]      virtual read address
//    dat_r        out  [ELEMENT_WIDTH]  combinational read data
//    read_hit     out  combinational, read_addr lies inside the tail run
//    varray_len   out  [ADDR_BITS+1]    one past the highest written address
//    is_new_group out  registered superscalar-group boundary flag
//    err          out  sticky protocol-error flag
// ============================================================================
module varray_multi #(
  parameter int ELEMENT_WIDTH = 18,
  parameter int ADDR_BITS     = 16,
  parameter int LOG_DEPTH     = 6,
  parameter int LEN_BITS      = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     we,
  input  logic [ADDR_BITS-1:0]     write_addr,
  input  logic [LEN_BITS-1:0]      write_len,
  input  logic [ELEMENT_WIDTH-1:0] dat_w,
  output logic                     full,
  output logic                     empty,
  output logic [LOG_DEPTH:0]       occupancy,
  input  logic                     re,
  input  logic [ADDR_BITS-1:0]     read_addr,
  output logic [ELEMENT_WIDTH-1:0] dat_r,
  output logic                     read_hit,
  output logic [ADDR_BITS:0]       varray_len,
  output logic                     is_new_group,
  output logic                     err
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int PTR_W = LOG_DEPTH + 1;
  localparam int END_W = ADDR_BITS + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
  localparam logic [END_W-1:0] END_ONE   = END_W'(1);
  // Exclusive upper bound of the virtual address space (2^ADDR_BITS).
  localparam logic [END_W-1:0] ADDR_SPAN = {1'b1, {ADDR_BITS{1'b0}}};

  // --------------------------------------------------------------------------
  // Entry storage. Never cleared: every read path is qualified by empty, so
  // stale entries left behind by reset or flush cannot be observed.
  // The exclusive end address is stored instead of the length so the read
  // comparisons need no adder.
  // --------------------------------------------------------------------------
  logic [ADDR_BITS-1:0]     start_mem [DEPTH];
  logic [END_W-1:0]         end_mem   [DEPTH];
  logic [ELEMENT_WIDTH-1:0] data_mem  [DEPTH];

  // Pointers carry one extra bit so that head == tail means empty and a
  // difference of DEPTH means full; all DEPTH slots are usable.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [END_W-1:0] vlen_q, vlen_d;
  logic             err_q, err_d;
  logic             ing_q, ing_d;

  // Combinational helpers
  logic [PTR_W-1:0]         w_occ;
  logic                     w_empty;
  logic                     w_full;
  logic [LOG_DEPTH-1:0]     w_head_idx;
  logic [LOG_DEPTH-1:0]     w_tail_idx;
  logic [ADDR_BITS-1:0]     w_tail_start;
  logic [END_W-1:0]         w_tail_end;
  logic [ELEMENT_WIDTH-1:0] w_tail_data;
  logic [END_W-1:0]         w_raddr_ext;
  logic [END_W-1:0]         w_raddr_p1;
  logic [END_W-1:0]         w_waddr_ext;
  logic [END_W-1:0]         w_wlen_ext;
  logic [END_W-1:0]         w_wr_end;
  logic                     w_hit;
  logic                     w_wr_ok;
  logic                     w_wr_accept;
  logic                     w_wr_err;
  logic                     w_rd_err;
  logic                     w_retire;

  // --------------------------------------------------------------------------
  // Occupancy and tail-entry view
  // --------------------------------------------------------------------------
  assign w_occ      = head_q - tail_q;
  assign w_empty    = (w_occ == '0);
  assign w_full     = (w_occ == FULL_CNT);
  assign w_head_idx = head_q[LOG_DEPTH-1:0];
  assign w_tail_idx = tail_q[LOG_DEPTH-1:0];

  assign w_tail_start = start_mem[w_tail_idx];
  assign w_tail_end   = end_mem[w_tail_idx];
  assign w_tail_data  = data_mem[w_tail_idx];

  // --------------------------------------------------------------------------
  // Address arithmetic, all one bit wider than the address so that a run
  // ending exactly at 2^ADDR_BITS and read_addr+1 at the top never wrap.
  // --------------------------------------------------------------------------
  assign w_raddr_ext = {1'b0, read_addr};
  assign w_raddr_p1  = w_raddr_ext + END_ONE;
  assign w_waddr_ext = {1'b0, write_addr};
  assign w_wlen_ext  = {{(END_W-LEN_BITS){1'b0}}, write_len};
  assign w_wr_end    = w_waddr_ext + w_wlen_ext;

  // --------------------------------------------------------------------------
  // Read path: only the tail run can hit because reads are non-decreasing
  // and the tail is retired once the reader reaches its last element.
  // --------------------------------------------------------------------------
  assign w_hit = !w_empty
               && (w_raddr_ext >= {1'b0, w_tail_start})
               && (w_raddr_ext <  w_tail_end);

  // A read at or beyond varray_len is a protocol error and never retires.
  assign w_rd_err = re && (w_raddr_ext >= vlen_q);
  assign w_retire = re && !w_empty && !w_rd_err && (w_raddr_p1 >= w_tail_end);

  // --------------------------------------------------------------------------
  // Write acceptance. full is taken from registered state, so a write into a
  // full queue is refused even when a retire frees a slot in the same cycle.
  // --------------------------------------------------------------------------
  assign w_wr_ok = !w_full
                && (write_len != '0)
                && (w_waddr_ext >= vlen_q)
                && (w_wr_end <= ADDR_SPAN);

  assign w_wr_accept = we && w_wr_ok && !flush;
  assign w_wr_err    = we && !w_wr_ok;

  // --------------------------------------------------------------------------
  // Next-state logic. flush overrides any write or read in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vlen_d = vlen_q;
    err_d  = err_q;
    ing_d  = ing_q;

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      vlen_d = '0;
      err_d  = 1'b0;
      ing_d  = 1'b1;
    end else begin
      if (w_wr_accept) begin
        head_d = head_q + PTR_ONE;
        vlen_d = w_wr_end;
      end
      if (w_retire) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (w_wr_err || w_rd_err) begin
        err_d = 1'b1;
      end
      // A new group starts after a zero-fill read or after the last element
      // of a run; between those points the flag holds while re is low.
      if (re) begin
        ing_d = !w_hit || (w_raddr_p1 == w_tail_end);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      vlen_q <= '0;
      err_q  <= 1'b0;
      ing_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vlen_q <= vlen_d;
      err_q  <= err_d;
      ing_q  <= ing_d;
    end
  end

  // Entry memory has no reset; a slot is loaded only by an accepted write.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      start_mem[w_head_idx] <= write_addr;
      end_mem[w_head_idx]   <= w_wr_end;
      data_mem[w_head_idx]  <= dat_w;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign occupancy    = w_occ;
  assign empty        = w_empty;
  assign full         = w_full;
  assign read_hit     = w_hit;
  assign dat_r        = w_hit ? w_tail_data : '0;
  assign varray_len   = vlen_q;
  assign is_new_group = ing_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_varray_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_varray_multi
//  Purpose  : Self-checking bench for varray_multi using a table of directed
//             one-cycle vectors with hand-computed expectations, plus short
//             hand-written sequences for the full queue and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_varray_multi;

  localparam int EW = 18;
  localparam int AB = 16;
  localparam int LD = 6;
  localparam int LB = 5;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          we;
  logic [AB-1:0] write_addr;
  logic [LB-1:0] write_len;
  logic [EW-1:0] dat_w;
  logic          full;
  logic          empty;
  logic [LD:0]   occupancy;
  logic          re;
  logic [AB-1:0] read_addr;
  logic [EW-1:0] dat_r;
  logic          read_hit;
  logic [AB:0]   varray_len;
  logic          is_new_group;
  logic          err;

  int n_total;
  int n_bad;

  varray_multi #(
    .ELEMENT_WIDTH(EW),
    .ADDR_BITS    (AB),
    .LOG_DEPTH    (LD),
    .LEN_BITS     (LB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .we          (we),
    .write_addr  (write_addr),
    .write_len   (write_len),
    .dat_w       (dat_w),
    .full        (full),
    .empty       (empty),
    .occupancy   (occupancy),
    .re          (re),
    .read_addr   (read_addr),
    .dat_r       (dat_r),
    .read_hit    (read_hit),
    .varray_len  (varray_len),
    .is_new_group(is_new_group),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus. hit/dat are checked before the clock edge, the
  // remaining fields are the registered state after the edge.
  typedef struct {
    logic          fl;
    logic          w;
    logic [AB-1:0] wa;
    logic [LB-1:0] wl;
    logic [EW-1:0] wd;
    logic          r;
    logic [AB-1:0] ra;
    logic          e_hit;
    logic [EW-1:0] e_dat;
    int            e_occ;
    int            e_vlen;
    logic          e_ing;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic w, int wa, int wl, int wd,
                              logic r, int ra, logic e_hit, int e_dat,
                              int e_occ, int e_vlen, logic e_ing, logic e_err);
    vec_t v;
    v.fl = fl;  v.w = w;  v.wa = AB'(wa);  v.wl = LB'(wl);  v.wd = EW'(wd);
    v.r = r;    v.ra = AB'(ra);
    v.e_hit = e_hit;  v.e_dat = EW'(e_dat);  v.e_occ = e_occ;
    v.e_vlen = e_vlen;  v.e_ing = e_ing;  v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    flush      = v.fl;
    we         = v.w;
    write_addr = v.wa;
    write_len  = v.wl;
    dat_w      = v.wd;
    re         = v.r;
    read_addr  = v.ra;
    #1;
    chk({tag, ".read_hit"}, read_hit, v.e_hit);
    chk({tag, ".dat_r"}, dat_r, v.e_dat);
    @(posedge clk);
    #1;
    chk({tag, ".occupancy"}, occupancy, v.e_occ);
    chk({tag, ".empty"}, empty, (v.e_occ == 0));
    chk({tag, ".full"}, full, (v.e_occ == 64));
    chk({tag, ".varray_len"}, varray_len, v.e_vlen);
    chk({tag, ".is_new_group"}, is_new_group, v.e_ing);
    chk({tag, ".err"}, err, v.e_err);
    flush = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    flush = 1'b0; we = 1'b0; re = 1'b0;
    write_addr = '0; write_len = '0; dat_w = '0; read_addr = '0;

    //          fl w  wa     wl  wd    r  ra     hit dat occ vlen   ing err
    // basic run
    tbl.push_back(mk(0, 1, 0,     3,  5,    0, 0,     0, 0,  1, 3,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 0,     1, 5,  1, 3,     0, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 1,     1, 5,  1, 3,     0, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 2,     1, 5,  0, 3,     1, 0));
    // gap between runs
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 0,     2,  10,   0, 0,     0, 0,  1, 2,     1, 0));
    tbl.push_back(mk(0, 1, 5,     1,  11,   0, 0,     1, 10, 2, 6,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 0,     1, 10, 2, 6,     0, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 1,     1, 10, 1, 6,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 2,     0, 0,  1, 6,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 3,     0, 0,  1, 6,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 4,     0, 0,  1, 6,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 5,     1, 11, 0, 6,     1, 0));
    // illegal writes
    tbl.push_back(mk(0, 1, 6,     0,  1,    0, 0,     0, 0,  0, 6,     1, 1));
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 10,    2,  1,    0, 0,     0, 0,  1, 12,    1, 0));
    tbl.push_back(mk(0, 1, 5,     1,  1,    0, 0,     0, 0,  1, 12,    1, 1));
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 65530, 10, 1,    0, 0,     0, 0,  0, 0,     1, 1));
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 65520, 16, 7,    0, 0,     0, 0,  1, 65536, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 65535, 1, 7,  0, 65536, 1, 0));
    // simultaneous write and read on an empty queue (read past varray_len)
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 0,     1,  9,    1, 0,     0, 0,  1, 1,     1, 1));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 0,     1, 9,  0, 1,     1, 1));
    // write while another entry retires
    tbl.push_back(mk(1, 0, 0,     0,  0,    0, 0,     0, 0,  0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 0,     1,  1,    0, 0,     0, 0,  1, 1,     1, 0));
    tbl.push_back(mk(0, 1, 1,     1,  2,    0, 0,     1, 1,  2, 2,     1, 0));
    tbl.push_back(mk(0, 1, 2,     1,  3,    1, 0,     1, 1,  2, 3,     1, 0));
    tbl.push_back(mk(0, 0, 0,     0,  0,    1, 1,     1, 2,  1, 3,     1, 0));
    // flush with three entries queued and err set; flush beats we/re
    tbl.push_back(mk(0, 1, 3,     1,  4,    0, 2,     1, 3,  2, 4,     1, 0));
    tbl.push_back(mk(0, 1, 4,     1,  5,    0, 2,     1, 3,  3, 5,     1, 0));
    tbl.push_back(mk(0, 1, 0,     1,  0,    0, 2,     1, 3,  3, 5,     1, 1));
    tbl.push_back(mk(1, 1, 5,     1,  1,    1, 2,     1, 3,  0, 0,     1, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset.empty", empty, 1);
    chk("reset.full", full, 0);
    chk("reset.occupancy", occupancy, 0);
    chk("reset.varray_len", varray_len, 0);
    chk("reset.is_new_group", is_new_group, 1);
    chk("reset.err", err, 0);
    chk("reset.read_hit", read_hit, 0);

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill all 64 slots with unit runs at addresses 0..63.
    for (int i = 0; i < 64; i++) begin
      apply(mk(0, 1, i, 1, 100 + i, 0, 0, (i != 0), (i != 0) ? 100 : 0,
               i + 1, i + 1, 1, 0), $sformatf("fill%0d", i));
    end
    // 65th write is refused.
    apply(mk(0, 1, 64, 1, 164, 0, 0, 1, 100, 64, 64, 1, 1), "overfill");
    // One retire frees a slot.
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 100, 63, 64, 1, 1), "retire_one");
    // Next write lands in the wrapped slot.
    apply(mk(0, 1, 64, 1, 164, 0, 1, 1, 101, 64, 65, 1, 1), "refill");
    // Drain everything, crossing the pointer wrap.
    for (int k = 1; k <= 64; k++) begin
      apply(mk(0, 0, 0, 0, 0, 1, k, 1, 100 + k, 64 - k, 65, 1, 1),
            $sformatf("drain%0d", k));
    end

    // Asynchronous reset between clock edges.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "pre_rst_flush");
    apply(mk(0, 1, 0, 2, 3, 0, 0, 0, 0, 1, 2, 1, 0), "pre_rst_wr");
    apply(mk(0, 1, 0, 1, 0, 1, 0, 1, 3, 1, 2, 0, 1), "pre_rst_rd");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.empty", empty, 1);
    chk("arst.occupancy", occupancy, 0);
    chk("arst.varray_len", varray_len, 0);
    chk("arst.err", err, 0);
    chk("arst.is_new_group", is_new_group, 1);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 1, 4, 2, 8, 0, 4, 0, 0, 1, 6, 1, 0), "post_rst_wr");
    apply(mk(0, 0, 0, 0, 0, 1, 4, 1, 8, 1, 6, 0, 0), "post_rst_rd");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
